// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit and receive paths.
// Holds the FSM state type, line-format constants and the baud divider helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_t;

   localparam logic UART_IDLE_LVL  = 1'b1;
   localparam int   UART_DATA_BITS = 8;

   // Number of sysclk cycles per bit on the line (integer divide).
   function automatic int bit_div(input int clk, input int baud);
      return clk / baud;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter used by both UART directions.
// Counts 0..DIV-1 and raises tick at the terminal count; restart holds it at zero.
module uart_baud_tick #(
   parameter int DIV = 16
) (
   input  logic                       sysclk,
   input  logic                       reset_n,
   input  logic                       restart,
   output logic [$clog2(DIV)-1:0]     count,
   output logic                       tick
);

   localparam int CW = $clog2(DIV);

   assign tick = (count == CW'(DIV - 1));

   // Free-running bit counter that wraps at each bit boundary or when restarted.
   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (restart || tick) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_engine.sv
// Transmit-side UART engine: one-byte holding register feeding a shift register,
// framed as 8N1, or 8E1 when UART_TX_PARITY_EN is defined. LSB first.
// All line-facing outputs are registered so UART_TX never glitches.
module uart_tx_engine
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 9600
) (
   input  logic       sysclk,
   input  logic       reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       UART_TX
);

   localparam int BIT_DIV = bit_div(CLK_FREQ, BAUD);
   localparam int CNT_W   = $clog2(BIT_DIV);

   uart_state_t      state;
   logic [7:0]       holding_data;
   logic             holding_full;
   logic [7:0]       shift;
   logic [2:0]       bit_idx;
   logic [CNT_W-1:0] baud_count;
   logic             baud_tick;
   logic             accept;
   logic             load;
`ifdef UART_TX_PARITY_EN
   logic             parity_bit;
`endif

   assign tx_ready = ~holding_full;
   assign accept   = tx_valid & ~holding_full;
   // The engine takes the held byte when idle, or at the end of a stop bit so frames abut.
   assign load     = holding_full &
                     ((state == IDLE) || ((state == STOP) && baud_tick));

   uart_baud_tick #(
      .DIV (BIT_DIV)
   ) u_baud (
      .sysclk  (sysclk),
      .reset_n (reset_n),
      .restart (state == IDLE),
      .count   (baud_count),
      .tick    (baud_tick)
   );

   // Holding register: a new byte wins over a simultaneous drain so nothing is lost.
   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         holding_full <= 1'b0;
         holding_data <= '0;
      end else if (accept) begin
         holding_full <= 1'b1;
         holding_data <= tx_data;
      end else if (load) begin
         holding_full <= 1'b0;
      end
   end

   // Frame sequencer: line level, busy and done are set alongside the next state.
   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         shift   <= '0;
         bit_idx <= '0;
         UART_TX <= UART_IDLE_LVL;
         tx_busy <= 1'b0;
         tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         tx_done <= (state == STOP) && (baud_count == CNT_W'(BIT_DIV - 2));
         case (state)
            IDLE: begin
               UART_TX <= UART_IDLE_LVL;
               tx_busy <= 1'b0;
               if (load) begin
                  shift   <= holding_data;
`ifdef UART_TX_PARITY_EN
                  parity_bit <= ^holding_data;
`endif
                  state   <= START;
                  UART_TX <= 1'b0;
                  tx_busy <= 1'b1;
               end
            end
            START: begin
               if (baud_tick) begin
                  state   <= DATA;
                  bit_idx <= '0;
                  UART_TX <= shift[0];
               end
            end
            DATA: begin
               if (baud_tick) begin
                  if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                     state   <= PARITY;
                     UART_TX <= parity_bit;
`else
                     state   <= STOP;
                     UART_TX <= UART_IDLE_LVL;
`endif
                  end else begin
                     shift   <= shift >> 1;
                     UART_TX <= shift[1];
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (baud_tick) begin
                  state   <= STOP;
                  UART_TX <= UART_IDLE_LVL;
               end
            end
`endif
            STOP: begin
               if (baud_tick) begin
                  if (load) begin
                     shift   <= holding_data;
`ifdef UART_TX_PARITY_EN
                     parity_bit <= ^holding_data;
`endif
                     state   <= START;
                     UART_TX <= 1'b0;
                  end else begin
                     state   <= IDLE;
                     UART_TX <= UART_IDLE_LVL;
                     tx_busy <= 1'b0;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               UART_TX <= UART_IDLE_LVL;
               tx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine at CLK_FREQ=16, BAUD=1 (16 cycles per bit).
// Define UART_TX_PARITY_EN to also exercise the 8E1 frame.
module tb_uart_tx_engine;

`ifdef UART_TX_PARITY_EN
   localparam int FL = 176;
`else
   localparam int FL = 160;
`endif

   logic       sysclk;
   logic       reset_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_busy;
   logic       tx_done;
   logic       UART_TX;

   int compared;
   int mismatched;

   uart_tx_engine #(
      .CLK_FREQ (16),
      .BAUD     (1)
   ) dut (
      .sysclk   (sysclk),
      .reset_n  (reset_n),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done),
      .UART_TX  (UART_TX)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   // Expected line level k cycles after the edge that started the frame (k = 1..FL).
   function automatic logic exp_line(input logic [7:0] b, input int k);
      int slot;
      if (k < 1 || k > FL) return 1'b1;
      slot = (k - 1) / 16;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return b[slot-1];
`ifdef UART_TX_PARITY_EN
      if (slot == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   task automatic test_reset;
      reset_n  = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      #23;
      compared++;
      if (UART_TX !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_state: got tx=%b ready=%b busy=%b done=%b, want 1 1 0 0",
                  UART_TX, tx_ready, tx_busy, tx_done);
      end
      @(negedge sysclk);
      reset_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(posedge sysclk); #1;
         compared++;
         if (UART_TX !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL idle_cycle%0d: got tx=%b ready=%b busy=%b done=%b, want 1 1 0 0",
                     i, UART_TX, tx_ready, tx_busy, tx_done);
         end
      end
   endtask

   task automatic test_single_frame(input logic [7:0] b);
      @(negedge sysclk);
      tx_data  = b;
      tx_valid = 1'b1;
      @(posedge sysclk); #1;
      tx_valid = 1'b0;
      for (int k = 1; k <= FL + 1; k++) begin
         @(posedge sysclk); #1;
         compared++;
         if (UART_TX !== exp_line(b, k)) begin
            mismatched++;
            $display("[TB] FAIL frame_%02h_line k=%0d: got %b want %b", b, k, UART_TX, exp_line(b, k));
         end
         compared++;
         if (tx_done !== (k == FL)) begin
            mismatched++;
            $display("[TB] FAIL frame_%02h_done k=%0d: got %b want %b", b, k, tx_done, (k == FL));
         end
         compared++;
         if (tx_busy !== (k <= FL)) begin
            mismatched++;
            $display("[TB] FAIL frame_%02h_busy k=%0d: got %b want %b", b, k, tx_busy, (k <= FL));
         end
      end
      compared++;
      if (tx_ready !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL frame_%02h_ready_after: got %b want 1", b, tx_ready);
      end
   endtask

   task automatic test_back_to_back;
      logic exp;
      logic exp_rdy;
      @(negedge sysclk);
      tx_data  = 8'hA3;
      tx_valid = 1'b1;
      @(posedge sysclk); #1;
      tx_data = 8'h0F;
      compared++;
      if (tx_ready !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL b2b_ready_k0: got %b want 0", tx_ready);
      end
      for (int k = 1; k <= 2 * FL + 1; k++) begin
         @(posedge sysclk); #1;
         if (k == 2) tx_valid = 1'b0;
         exp = (k <= FL) ? exp_line(8'hA3, k) : exp_line(8'h0F, k - FL);
         compared++;
         if (UART_TX !== exp) begin
            mismatched++;
            $display("[TB] FAIL b2b_line k=%0d: got %b want %b", k, UART_TX, exp);
         end
         exp_rdy = (k == 1) || (k > FL);
         compared++;
         if (tx_ready !== exp_rdy) begin
            mismatched++;
            $display("[TB] FAIL b2b_ready k=%0d: got %b want %b", k, tx_ready, exp_rdy);
         end
         compared++;
         if (tx_busy !== (k <= 2 * FL)) begin
            mismatched++;
            $display("[TB] FAIL b2b_busy k=%0d: got %b want %b", k, tx_busy, (k <= 2 * FL));
         end
         compared++;
         if (tx_done !== (k == FL || k == 2 * FL)) begin
            mismatched++;
            $display("[TB] FAIL b2b_done k=%0d: got %b want %b", k, tx_done, (k == FL || k == 2 * FL));
         end
      end
   endtask

   task automatic test_ignore_when_full;
      logic exp;
      @(negedge sysclk);
      tx_data  = 8'h3C;
      tx_valid = 1'b1;
      @(posedge sysclk); #1;
      tx_data = 8'hC5;
      for (int k = 1; k <= 2 * FL + 20; k++) begin
         @(posedge sysclk); #1;
         if (k == 2) tx_valid = 1'b0;
         if (k == 5) begin
            tx_data  = 8'hFF;
            tx_valid = 1'b1;
         end
         if (k == 6) tx_valid = 1'b0;
         exp = (k <= FL) ? exp_line(8'h3C, k) : exp_line(8'hC5, k - FL);
         compared++;
         if (UART_TX !== exp) begin
            mismatched++;
            $display("[TB] FAIL ignore_line k=%0d: got %b want %b", k, UART_TX, exp);
         end
      end
      compared++;
      if (tx_busy !== 1'b0 || tx_ready !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL ignore_idle_after: got busy=%b ready=%b want 0 1", tx_busy, tx_ready);
      end
      test_single_frame(8'hFF);
   endtask

   task automatic test_reset_mid_frame;
      @(negedge sysclk);
      tx_data  = 8'h81;
      tx_valid = 1'b1;
      @(posedge sysclk); #1;
      tx_valid = 1'b0;
      repeat (16 + 16 * 3 + 5) @(posedge sysclk);
      #1;
      compared++;
      if (tx_busy !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL rst_mid_busy_before: got %b want 1", tx_busy);
      end
      #2;
      reset_n = 1'b0;
      #1;
      compared++;
      if (UART_TX !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1 || tx_done !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL rst_mid_async: got tx=%b busy=%b ready=%b done=%b want 1 0 1 0",
                  UART_TX, tx_busy, tx_ready, tx_done);
      end
      @(negedge sysclk);
      reset_n = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(posedge sysclk); #1;
         compared++;
         if (UART_TX !== 1'b1 || tx_busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rst_mid_residual i=%0d: got tx=%b busy=%b want 1 0", i, UART_TX, tx_busy);
         end
      end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity;
      test_single_frame(8'h07);
      test_single_frame(8'h03);
   endtask
`endif

   initial begin
      compared   = 0;
      mismatched = 0;
      test_reset();
      test_single_frame(8'h55);
      test_back_to_back();
      test_ignore_when_full();
      test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
